// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-port round-robin arbiter in front of a combinational instruction memory
// One-cycle read latency; out-of-range addresses return zero data with an error flag.
module imem_arbiter #(
  parameter int N     = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 50
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [N-1:0]  rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [N-1:0]  rdata1,
  output logic          err1,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_q,
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic          last_grant_q, last_grant_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [N-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [15:0]   gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;
  logic          out_of_range;
  logic [N-1:0]  read_word;

  // last_grant_q = 1 means port 1 was served most recently, so port 0 wins a tie
  always_comb begin
    gnt0 = reset & req0 & (~req1 | last_grant_q);
    gnt1 = reset & req1 & (~req0 | ~last_grant_q);
  end

  always_comb begin
    imem_addr = '0;
    if (gnt0) begin
      imem_addr = addr0;
    end else if (gnt1) begin
      imem_addr = addr1;
    end
    out_of_range = ({1'b0, imem_addr} >= DEPTH_L);
    read_word    = out_of_range ? '0 : imem_q;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end

    rvalid0_d = gnt0;
    rdata0_d  = gnt0 ? read_word : rdata0_q;
    err0_d    = gnt0 ? out_of_range : err0_q;
    rvalid1_d = gnt1;
    rdata1_d  = gnt1 ? read_word : rdata1_q;
    err1_d    = gnt1 ? out_of_range : err1_q;

    gcnt0_d = gcnt0_q;
    if (gnt0 && (gcnt0_q != 16'hFFFF)) begin
      gcnt0_d = gcnt0_q + 16'd1;
    end
    gcnt1_d = gcnt1_q;
    if (gnt1 && (gcnt1_q != 16'hFFFF)) begin
      gcnt1_d = gcnt1_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rdata0_q     <= '0;
      err0_q       <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata1_q     <= '0;
      err1_q       <= 1'b0;
      gcnt0_q      <= '0;
      gcnt1_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rvalid0_q    <= rvalid0_d;
      rdata0_q     <= rdata0_d;
      err0_q       <= err0_d;
      rvalid1_q    <= rvalid1_d;
      rdata1_q     <= rdata1_d;
      err1_q       <= err1_d;
      gcnt0_q      <= gcnt0_d;
      gcnt1_q      <= gcnt1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rdata0  = rdata0_q;
  assign err0    = err0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata1  = rdata1_q;
  assign err1    = err1_q;
  assign gcnt0   = gcnt0_q;
  assign gcnt1   = gcnt1_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter
// Driver predicts grants and pushes expected responses; a negedge monitor pops and compares.
module tb_imem_arbiter;
  localparam int N = 32;
  localparam int AW = 6;
  localparam int DEPTH = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [N-1:0]  rdata0, rdata1, imem_q;
  logic [AW-1:0] imem_addr;
  logic [15:0]   gcnt0, gcnt1;
  logic [N-1:0]  mem [64];

  imem_arbiter #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .imem_addr(imem_addr), .imem_q(imem_q), .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  assign imem_q = mem[imem_addr];
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [N-1:0] data;
    logic         err;
  } exp_t;

  exp_t         q0[$], q1[$];
  logic [N-1:0] held_data [2];
  logic         held_err [2];
  int           last_port;
  int           cnt [2];
  int           granted;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat(input int c);
    return (c > 65535) ? 16'hFFFF : c[15:0];
  endfunction

  task automatic mon_port(input int p, input logic rv, input logic [N-1:0] rd, input logic er);
    exp_t e;
    bit   due;
    due = 1'b0;
    if (p == 0 && q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      due = 1'b1;
    end
    if (p == 1 && q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      due = 1'b1;
    end
    check($sformatf("rvalid%0d", p), rv, due);
    if (due) begin
      held_data[p] = e.data;
      held_err[p]  = e.err;
    end
    check($sformatf("rdata%0d", p), rd, held_data[p]);
    check($sformatf("err%0d", p), er, held_err[p]);
  endtask

  always @(negedge clk) begin
    mon_port(0, rvalid0, rdata0, err0);
    mon_port(1, rvalid1, rdata1, err1);
  end

  task automatic model_reset();
    q0.delete();
    q1.delete();
    held_data[0] = '0;
    held_data[1] = '0;
    held_err[0]  = 1'b0;
    held_err[1]  = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    last_port = 1;
    granted = -1;
  endtask

  // One cycle of stimulus: predict the winner from the requests and who was served last
  task automatic step(input logic r0, input logic [AW-1:0] a0, input logic r1, input logic [AW-1:0] a1);
    int            w;
    logic [AW-1:0] wa;
    exp_t          e;
    @(posedge clk);
    #1;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    if (r0 && r1) w = (last_port == 0) ? 1 : 0;
    else if (r0)  w = 0;
    else if (r1)  w = 1;
    else          w = -1;
    wa = (w == 0) ? a0 : (w == 1) ? a1 : '0;
    check("gnt0", gnt0, w == 0);
    check("gnt1", gnt1, w == 1);
    check("imem_addr", imem_addr, wa);
    check("gcnt0", gcnt0, sat(cnt[0]));
    check("gcnt1", gcnt1, sat(cnt[1]));
    if (w >= 0) begin
      e.due  = cyc + 1;
      e.err  = (int'(wa) >= DEPTH);
      e.data = e.err ? '0 : mem[wa];
      if (w == 0) q0.push_back(e);
      else        q1.push_back(e);
      cnt[w]++;
      last_port = w;
    end
    granted = w;
  endtask

  // Asserted mid-cycle, so a grant shown in this cycle must never produce a response
  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_imem_addr", imem_addr, '0);
    check("rst_gcnt0", gcnt0, 16'd0);
    check("rst_gcnt1", gcnt1, 16'd0);
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic          r [2];
  logic [AW-1:0] a [2];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom() | 32'h1;
    mem[0] = 32'hf8000001;
    mem[1] = 32'hf8008002;
    mem[2] = 32'hf8000203;
    mem[3] = 32'h8b050083;
    mem[4] = 32'hf8018003;
    mem[49] = 32'h0;
    model_reset();
    req0 = 1'b1; req1 = 1'b1;
    #2;
    check("init_gnt0", gnt0, 1'b0);
    check("init_gnt1", gnt1, 1'b0);
    check("init_imem_addr", imem_addr, '0);
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    check("gcnt0_after_4", gcnt0, 16'd4);
    repeat (5) step(1'b0, '0, 1'b0, '0);

    step(1'b0, '0, 1'b1, AW'(49));
    step(1'b0, '0, 1'b1, AW'(50));
    step(1'b0, '0, 1'b1, AW'(0));
    step(1'b0, '0, 1'b0, '0);

    step(1'b1, AW'(2), 1'b0, '0);
    pulse_reset();
    for (int i = 0; i < 6; i++) step(1'b1, AW'(3), 1'b1, AW'(4));
    step(1'b0, '0, 1'b0, '0);

    r[0] = 1'b0; r[1] = 1'b0; a[0] = '0; a[1] = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (r[p] && granted != p) begin
          if ($urandom_range(0, 7) == 0) r[p] = 1'b0;
        end else begin
          r[p] = ($urandom_range(0, 3) != 0);
          a[p] = AW'($urandom_range(0, 63));
        end
      end
      step(r[0], a[0], r[1], a[1]);
      if (i % 700 == 699) begin
        pulse_reset();
        r[0] = 1'b0; r[1] = 1'b0;
      end
    end

    pulse_reset();
    for (int i = 0; i < 65545; i++) step(1'b1, AW'($urandom_range(0, 63)), 1'b0, '0);
    check("gcnt0_saturated", gcnt0, 16'hFFFF);
    repeat (3) step(1'b0, '0, 1'b0, '0);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
